// File: rtl/div_iter_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// EX drives the request side; the divider returns busy/result.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               annul;
  logic               busy;
  logic               result_ok;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start,
    output signed_op,
    output dividend,
    output divisor,
    output annul,
    input  busy,
    input  result_ok,
    input  result
  );

  modport slave (
    input  start,
    input  signed_op,
    input  dividend,
    input  divisor,
    input  annul,
    output busy,
    output result_ok,
    output result
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for EX-stage DIV/DIVU.
// Returns {remainder, quotient} in hilo layout after a fixed latency.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sop_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   div_q;
  logic               qneg_q;
  logic               rneg_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               ok_q;
  logic [2*WIDTH-1:0] res_q;

  logic               idle_like;
  logic               accept;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               borrow;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  assign idle_like = (state_q == IDLE) ||
                     (state_q == DONE);
  assign accept    = idle_like &&
                     bus.start && !bus.annul;

  assign a_abs = (sop_q && a_q[WIDTH-1]) ?
                 (~a_q + ONE) : a_q;
  assign b_abs = (sop_q && b_q[WIDTH-1]) ?
                 (~b_q + ONE) : b_q;

  // One extra bit on each side keeps |-2^(W-1)| and the borrow exact.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} -
                   {2'b00, div_q};
  assign borrow  = diff[WIDTH+1];

  assign rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;
  assign quo_fix = qneg_q ? (~quo_q + ONE) : quo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sop_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      ok_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            a_q     <= bus.dividend;
            b_q     <= bus.divisor;
            sop_q   <= bus.signed_op;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end else begin
            state_q <= IDLE;
          end
        end
        PREP: begin
          if (bus.annul) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q   <= '0;
            quo_q   <= a_abs;
            div_q   <= b_abs;
            qneg_q  <= sop_q &
                       (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg_q  <= sop_q & a_q[WIDTH-1];
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.annul) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= borrow ? shifted[WIDTH-1:0]
                            : diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~borrow};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          if (bus.annul) begin
            state_q <= IDLE;
          end else begin
            res_q   <= {rem_fix, quo_fix};
            ok_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.result_ok = ok_q;
  assign bus.result    = res_q;
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: spec vectors, random ops vs reference model,
// and hand-written annul/reset/overlap sequences.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus ();
  div_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  localparam int LAT = 34;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(
      input bit s, input logic [31:0] a,
      input logic [31:0] b);
    logic [31:0] aa, bb, q, r;
    aa = (s && a[31]) ? 32'(-a) : a;
    bb = (s && b[31]) ? 32'(-b) : b;
    if (bb == 0) begin
      q = 32'hFFFF_FFFF;
      r = aa;
    end else begin
      q = aa / bb;
      r = aa % bb;
    end
    if (s && (a[31] ^ b[31])) q = 32'(-q);
    if (s && a[31]) r = 32'(-r);
    return {r, q};
  endfunction

  task automatic run_op(input bit s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [63:0] res,
                        output int lat);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.result_ok) begin
        lat = i;
        break;
      end
    end
    res = bus.result;
  endtask

  task automatic watch_no_ok(input string nm,
                             input int n,
                             input logic [63:0] keep);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.result_ok) seen++;
    end
    chk({nm, "_no_ok"}, 64'(seen), 64'd0);
    chk({nm, "_result_kept"}, bus.result, keep);
  endtask

  vec_t vecs[7];
  logic [63:0] res, prev, exp;
  int lat;

  initial begin
    vecs[0] = '{1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE,
                64'h00000001_FFFFFFFD};
    vecs[3] = '{1'b0, 32'd5, 32'd0,
                64'h00000005_FFFFFFFF};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                64'h00000000_80000000};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd1,
                64'h00000000_FFFFFFFF};
    vecs[6] = '{1'b1, 32'h80000000, 32'd1,
                64'h00000000_80000000};

    bus.start     = 1'b0;
    bus.annul     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_ok", 64'(bus.result_ok), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b,
             res, lat);
      chk($sformatf("vec%0d_result", i),
          res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i),
          64'(lat), 64'(LAT));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse_1cyc", i),
          64'(bus.result_ok), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      bit s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 3);
        1: b = 32'(-$urandom_range(1, 5));
        2: a = 32'h80000000;
        default: ;
      endcase
      run_op(s, a, b, res, lat);
      chk($sformatf("rand%0d_result", i),
          res, ref_div(s, a, b));
      chk($sformatf("rand%0d_latency", i),
          64'(lat), 64'(LAT));
    end

    // annul and start together in IDLE: annul wins
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    chk("annul_start_idle_busy",
        64'(bus.busy), 64'd0);

    // annul mid-RUN
    prev = bus.result;
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("annul_pre_busy", 64'(bus.busy), 64'd1);
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    chk("annul_busy_drop", 64'(bus.busy), 64'd0);
    watch_no_ok("annul", 2, prev);
    run_op(1'b0, 32'd1000, 32'd3, res, lat);
    chk("after_annul_result", res,
        ref_div(1'b0, 32'd1000, 32'd3));
    chk("after_annul_latency", 64'(lat), 64'(LAT));

    // asynchronous reset mid-RUN
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.dividend  = 32'hFFFF_0000;
    bus.divisor   = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_ok", 64'(bus.result_ok), 64'd0);
    chk("arst_result", bus.result, 64'd0);
    @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 64'(bus.busy), 64'd0);
    watch_no_ok("arst", 45, 64'd0);

    // second start held while busy is ignored
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(posedge clk); #1;
    bus.dividend  = 32'd999;
    bus.divisor   = 32'd10;
    bus.signed_op = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int i = 21; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.result_ok) begin
        lat = i;
        break;
      end
    end
    chk("busy_start_result", bus.result,
        64'h00000002_0000000E);
    chk("busy_start_latency", 64'(lat), 64'(LAT));

    // back-to-back start in the DONE cycle
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, res, lat);
    chk("b2b_first", res,
        ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
    run_op(1'b0, 32'd12345, 32'd11, res, lat);
    chk("b2b_second", res,
        ref_div(1'b0, 32'd12345, 32'd11));
    chk("b2b_latency", 64'(lat), 64'(LAT));

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
